seq_mult_ctrl: RTL
==================

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width in bits (legal range 2..32).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 start  input  1  SHALL be the multiply request, sampled on the clk rising edge.
REQ-005 a  input  WIDTH  SHALL be the unsigned multiplicand, captured when start is accepted.
REQ-006 b  input  WIDTH  SHALL be the unsigned multiplier, captured when start is accepted.
REQ-007 busy  output  1  SHALL be high while an operation is in progress (state RUN).
REQ-008 done  output  1  SHALL be a one-cycle completion pulse (state DONE).
REQ-009 product  output  2*WIDTH  SHALL be the registered unsigned result a*b.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 IDLE: start=1 SHALL capture a into the multiplicand register and b into the multiplier register, clear the accumulator and the step counter, and move to RUN.
REQ-012 start SHALL be ignored in RUN and DONE; operands SHALL NOT change mid-operation.
REQ-013 RUN: each cycle, one adder of width WIDTH+1 SHALL compute acc_hi + (multiplier LSB ? multiplicand : 0); the {carry, sum, acc_lo, multiplier} chain SHALL then shift right one bit.
REQ-014 The single adder SHALL be the only arithmetic resource, time-shared across all WIDTH steps; no carry SHALL be lost (carry-out enters the MSB on the shift).
REQ-015 The step counter SHALL count 0..WIDTH-1; after the step with count WIDTH-1 the FSM SHALL move to DONE.
REQ-016 On entry to DONE, product SHALL be loaded with the full 2*WIDTH accumulator; DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency: with start accepted at rising edge t0, done SHALL be high for exactly the cycle between edges t0+WIDTH and t0+WIDTH+1; busy SHALL be high for the WIDTH cycles between edges t0 and t0+WIDTH.
REQ-018 busy and done SHALL never be high simultaneously.
REQ-019 product SHALL hold its value from the done cycle until the next done cycle, including through IDLE and the next RUN.
REQ-020 Back-to-back: start held high continuously SHALL start a new operation on the first edge in IDLE after DONE, i.e. one operation every WIDTH+2 cycles.
REQ-021 Boundary operands (a or b equal to 0, all-ones) SHALL yield exact results; all-ones*all-ones SHALL equal 2^(2*WIDTH) - 2^(WIDTH+1) + 1.
REQ-022 Outputs SHALL be driven directly from registers (no combinational path from inputs to outputs).

Reset
REQ-023 rst=1 SHALL immediately, independent of clk, force state to IDLE, busy=0, done=0, product=0, and clear the accumulator, operand registers and step counter.
REQ-024 rst asserted mid-operation SHALL abandon the operation with no done pulse; product SHALL read 0.
REQ-025 The first start SHALL be accepted on the first rising edge at which rst=0 and start=1.

Verification (WIDTH=8)
REQ-026 a=13, b=11, start pulse at t0 -> busy high 8 cycles, done pulse at t0+8..t0+9, product=143 (0x008F).
REQ-027 a=0xFF, b=0xFF -> product=0xFE01 at done; a=0x00, b=0x5A -> product=0x0000.
REQ-028 Start a=3, b=5; during RUN pulse start with a=7, b=9 -> second start ignored, product=15, exactly one done.
REQ-029 Start a=0x80, b=0x02; assert rst at cycle 4 of RUN -> busy=0, done=0, product=0 immediately; no done afterward; next start a=2, b=3 -> product=6.
REQ-030 start held high, operands 0x10*0x10 then 0x02*0x81 -> done pulses 10 cycles apart, products 0x0100 then 0x0102; product stable between pulses.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier.
// One WIDTH+1 bit adder is reused across WIDTH RUN cycles. A one-cycle DONE
// state then publishes the full 2*WIDTH-bit result on a held product register.
module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic             last_step;

  // Shared adder: the partial product is added only when the current multiplier LSB is set.
  always_comb begin
    addend    = mplier[0] ? mcand : '0;
    sum       = {1'b0, acc_hi} + {1'b0, addend};
    last_step = (count == CW'(WIDTH - 1));
  end

  // Next-state logic. DONE always lasts one cycle, and start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register. busy and done are registered copies of the next state, so they come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Datapath: capture operands, run the carry-preserving shift chain, and latch the result at the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          {acc_hi, acc_lo, mplier} <= {sum, acc_lo, mplier[WIDTH-1:1]};
          count                    <= count + CW'(1);
          if (last_step) begin
            product <= {sum, acc_lo[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
